// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end: PC register, instruction-memory address port
// and the IF/ID pipeline register. Handles decode back-pressure (stall),
// taken-branch/exception redirect with IF/ID flush, memory-wait bubbles and
// a saturating count of every bubble inserted into IF/ID.
//
// Ports
//   CLK           clock, all state changes on the rising edge
//   reset         synchronous, active-high
//   startpc       PC loaded while reset is high (no alignment applied)
//   imem_addr     fetch address, combinationally equal to the PC register
//   imem_data     instruction at imem_addr, meaningful when imem_ready=1
//   imem_ready    memory returned data this cycle
//   stall         decode cannot accept; PC and IF/ID hold
//   redirect      load redirect_pc (aligned) and flush IF/ID
//   redirect_pc   redirect target
//   currentpc     PC register
//   id_valid      IF/ID holds a real instruction
//   id_instr      IF/ID instruction (NOP_INSTR on reset and bubbles)
//   id_pc         address of id_instr
//   id_nextseqpc  id_pc + PC_STEP
//   bubble_count  saturating number of bubbles inserted
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int                 ADDR_W    = 64,
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_STEP   = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F,
    parameter int                 CNT_W     = 16
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  startpc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_ready,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  currentpc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [ADDR_W-1:0]  id_nextseqpc,
    output logic [CNT_W-1:0]   bubble_count
);

    // Redirect targets are forced onto a PC_STEP boundary; PC_STEP is
    // expected to be a power of two.
    localparam int                ALIGN_BITS = (PC_STEP > 1) ? $clog2(PC_STEP) : 0;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1));
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    // One action per edge, chosen by fixed priority.
    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_REDIRECT,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_FETCH
    } action_e;

    logic [ADDR_W-1:0]  r_pc;
    logic               r_id_valid;
    logic [INSTR_W-1:0] r_id_instr;
    logic [ADDR_W-1:0]  r_id_pc;
    logic [ADDR_W-1:0]  r_id_nextseqpc;
    logic [CNT_W-1:0]   r_bubble_count;

    action_e            w_act;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic [ADDR_W-1:0]  w_redirect_tgt;
    logic [CNT_W-1:0]   w_cnt_inc;

    // Sequential increment wraps modulo 2^ADDR_W by truncation.
    assign w_pc_inc       = r_pc + STEP;
    assign w_redirect_tgt = redirect_pc & ALIGN_MASK;
    assign w_cnt_inc      = (r_bubble_count == CNT_MAX) ? r_bubble_count
                                                        : r_bubble_count + CNT_W'(1);

    // Redirect outranks stall so a taken branch is never lost while decode
    // is back-pressuring; stall outranks a memory wait so a held bubble is
    // not counted twice.
    always_comb begin
        w_act = ACT_FETCH;
        if (reset)
            w_act = ACT_RESET;
        else if (redirect)
            w_act = ACT_REDIRECT;
        else if (stall)
            w_act = ACT_HOLD;
        else if (!imem_ready)
            w_act = ACT_BUBBLE;
    end

    always_ff @(posedge CLK) begin
        case (w_act)
            ACT_RESET: begin
                r_pc           <= startpc;
                r_id_valid     <= 1'b0;
                r_id_instr     <= NOP_INSTR;
                r_id_pc        <= '0;
                r_id_nextseqpc <= '0;
                r_bubble_count <= '0;
            end
            ACT_REDIRECT: begin
                r_pc           <= w_redirect_tgt;
                r_id_valid     <= 1'b0;
                r_id_instr     <= NOP_INSTR;
                r_bubble_count <= w_cnt_inc;
            end
            ACT_HOLD: begin
                // everything holds
            end
            ACT_BUBBLE: begin
                r_id_valid     <= 1'b0;
                r_id_instr     <= NOP_INSTR;
                r_bubble_count <= w_cnt_inc;
            end
            default: begin
                r_pc           <= w_pc_inc;
                r_id_valid     <= 1'b1;
                r_id_instr     <= imem_data;
                r_id_pc        <= r_pc;
                r_id_nextseqpc <= w_pc_inc;
            end
        endcase
    end

    assign imem_addr    = r_pc;
    assign currentpc    = r_pc;
    assign id_valid     = r_id_valid;
    assign id_instr     = r_id_instr;
    assign id_pc        = r_id_pc;
    assign id_nextseqpc = r_id_nextseqpc;
    assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances share stimulus, one with default
// parameters and one with a 2-bit bubble counter to exercise saturation.
// A behavioural model tracks expected state; a negedge process compares
// both instances to it every cycle, and directed steps pin literal values.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] startpc = 64'h1000;
    logic        imem_ready = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;

    logic [63:0] imem_addr0, currentpc0, id_pc0, id_nextseqpc0;
    logic [31:0] imem_data0, id_instr0;
    logic        id_valid0;
    logic [15:0] bubble_count0;

    logic [63:0] imem_addr1, currentpc1, id_pc1, id_nextseqpc1;
    logic [31:0] imem_data1, id_instr1;
    logic        id_valid1;
    logic [1:0]  bubble_count1;

    int checks = 0;
    int failures = 0;
    bit started = 0;

    always #5 CLK = ~CLK;

    // Instruction memory: word index relative to 0x1000 added to a base.
    function automatic logic [31:0] mem(input logic [63:0] a);
        logic [63:0] k;
        k = (a - 64'h1000) >> 2;
        return 32'h8B020020 + k[31:0];
    endfunction

    assign imem_data0 = mem(imem_addr0);
    assign imem_data1 = mem(imem_addr1);

    fetch_unit dut0 (
        .CLK(CLK), .reset(reset), .startpc(startpc), .imem_addr(imem_addr0),
        .imem_data(imem_data0), .imem_ready(imem_ready), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .currentpc(currentpc0),
        .id_valid(id_valid0), .id_instr(id_instr0), .id_pc(id_pc0),
        .id_nextseqpc(id_nextseqpc0), .bubble_count(bubble_count0)
    );

    fetch_unit #(.CNT_W(2)) dut1 (
        .CLK(CLK), .reset(reset), .startpc(startpc), .imem_addr(imem_addr1),
        .imem_data(imem_data1), .imem_ready(imem_ready), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .currentpc(currentpc1),
        .id_valid(id_valid1), .id_instr(id_instr1), .id_pc(id_pc1),
        .id_nextseqpc(id_nextseqpc1), .bubble_count(bubble_count1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_pc, m_id_pc, m_next;
    logic        m_valid;
    logic [31:0] m_instr;
    int          m_bub;   // unbounded bubble total; each DUT sees it clipped

    always @(posedge CLK) begin
        if (reset) begin
            m_pc <= startpc; m_valid <= 0; m_instr <= NOP;
            m_id_pc <= 0; m_next <= 0; m_bub <= 0;
        end else if (redirect) begin
            m_pc <= {redirect_pc[63:2], 2'b00};
            m_valid <= 0; m_instr <= NOP; m_bub <= m_bub + 1;
        end else if (stall) begin
            // nothing changes
        end else if (!imem_ready) begin
            m_valid <= 0; m_instr <= NOP; m_bub <= m_bub + 1;
        end else begin
            m_pc <= m_pc + 64'd4; m_valid <= 1; m_instr <= mem(m_pc);
            m_id_pc <= m_pc; m_next <= m_pc + 64'd4;
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            chk("imem_addr0", imem_addr0, m_pc);
            chk("currentpc0", currentpc0, m_pc);
            chk("id_valid0", 64'(id_valid0), 64'(m_valid));
            chk("id_instr0", 64'(id_instr0), 64'(m_instr));
            chk("id_pc0", id_pc0, m_id_pc);
            chk("id_nextseqpc0", id_nextseqpc0, m_next);
            chk("bubble_count0", 64'(bubble_count0), 64'((m_bub > 65535) ? 65535 : m_bub));
            chk("currentpc1", currentpc1, m_pc);
            chk("id_valid1", 64'(id_valid1), 64'(m_valid));
            chk("id_instr1", 64'(id_instr1), 64'(m_instr));
            chk("id_pc1", id_pc1, m_id_pc);
            chk("id_nextseqpc1", id_nextseqpc1, m_next);
            chk("bubble_count1", 64'(bubble_count1), 64'((m_bub > 3) ? 3 : m_bub));
        end
    end

    // Apply one cycle of inputs, then return just after the rising edge.
    task automatic cyc(input bit rst, input bit stl, input bit rdr,
                       input bit rdy, input logic [63:0] rpc);
        reset = rst; stall = stl; redirect = rdr; imem_ready = rdy; redirect_pc = rpc;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int exp1 [5] = '{1, 2, 3, 3, 3};
        #1;
        cyc(1, 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 64'h5555);   // reset wins over stall/redirect
        started = 1;
        chk("rst_pc", currentpc0, 64'h1000);
        chk("rst_valid", 64'(id_valid0), 64'd0);
        chk("rst_instr", 64'(id_instr0), 64'(NOP));
        chk("rst_idpc", id_pc0, 64'd0);
        chk("rst_bub", 64'(bubble_count0), 64'd0);

        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 0, 1, 0);
            chk("seq_idpc", id_pc0, 64'h1000 + 64'(4 * k));
            chk("seq_instr", 64'(id_instr0), 64'(32'h8B020020 + 32'(k)));
            chk("seq_next", id_nextseqpc0, 64'h1004 + 64'(4 * k));
            chk("seq_valid", 64'(id_valid0), 64'd1);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, (k != 1), 0);
            chk("stall_pc", currentpc0, 64'h1008);
            chk("stall_idpc", id_pc0, 64'h1004);
            chk("stall_instr", 64'(id_instr0), 64'h8B020021);
        end
        cyc(0, 0, 0, 1, 0);
        chk("resume_idpc", id_pc0, 64'h1008);
        cyc(0, 0, 0, 1, 0);
        chk("resume_idpc2", id_pc0, 64'h100C);
        chk("resume_bub", 64'(bubble_count0), 64'd0);

        cyc(0, 1, 1, 1, 64'h2003);
        chk("redir_pc", currentpc0, 64'h2000);
        chk("redir_valid", 64'(id_valid0), 64'd0);
        chk("redir_instr", 64'(id_instr0), 64'(NOP));
        chk("redir_idpc_held", id_pc0, 64'h100C);
        chk("redir_bub", 64'(bubble_count0), 64'd1);
        cyc(0, 0, 0, 1, 0);
        chk("redir_tgt_idpc", id_pc0, 64'h2000);
        chk("redir_tgt_valid", 64'(id_valid0), 64'd1);

        cyc(0, 0, 1, 1, 64'h3000);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("wait_pc", currentpc0, 64'h3000);
        chk("wait_bub", 64'(bubble_count0), 64'd4);
        chk("wait_bub_sat", 64'(bubble_count1), 64'd3);
        cyc(0, 0, 0, 1, 0);
        chk("wait_idpc", id_pc0, 64'h3000);

        cyc(1, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 0, 0);
            chk("sat_bub1", 64'(bubble_count1), 64'(exp1[k]));
            chk("sat_bub0", 64'(bubble_count0), 64'(k + 1));
        end
        cyc(1, 0, 0, 0, 0);
        chk("midrst_bub1", 64'(bubble_count1), 64'd0);
        chk("midrst_pc1", currentpc1, 64'h1000);
        chk("midrst_valid1", 64'(id_valid1), 64'd0);

        startpc = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("wrap_pc", currentpc0, 64'd0);
        chk("wrap_next", id_nextseqpc0, 64'd0);
        chk("wrap_idpc", id_pc0, 64'hFFFF_FFFF_FFFF_FFFC);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 2) startpc = {$urandom, $urandom};
            cyc(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 20),
                ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 75),
                {$urandom, $urandom});
        end

        @(negedge CLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
